adc_max10_core: RTL and testbench
=================================

ADC_MAX10_CORE -- requirements
Module: adc_max10_core

Interface
REQ-001 Parameter: ADDR_WIDTH, 4, register address width.
REQ-002 CLK  in  1  single clock; all logic on its rising edge.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 read_addr  in  ADDR_WIDTH  read register select; read_data  out  32  read value.
REQ-005 write_addr  in  ADDR_WIDTH; write_data  in  32; write_enable  in  1  write strobe, sampled at CLK rise.
REQ-006 ADC_C_Valid/ADC_C_SOP/ADC_C_EOP  out  1 each; ADC_C_Channel  out  5; ADC_C_Ready  in  1  (Avalon-ST command to ADC IP).
REQ-007 ADC_R_Valid/ADC_R_SOP/ADC_R_EOP  in  1 each; ADC_R_Channel  in  5; ADC_R_Data  in  12  (Avalon-ST response).
REQ-008 ADC_Trigger  in  1  asynchronous external start; ADC_Interrupt  out  1  interrupt request.

Function
REQ-009 Register map: 0 ADCS control/status; 1 ADMSK cell mask (bits 8:0); 2..9 ADR0..ADR7 results of cells 0..7; 10 ADRT result of cell T (cell 8); other addresses read 0, writes ignored.
REQ-010 Cell k (0..7) maps to ADC channel k; cell T maps to channel 17 (temperature sensor).
REQ-011 ADCS bits: EN=0, SC=1, TE=2, FR=3, IE=4, IF=5; bits 31:6 read 0.
REQ-012 Reads are combinational: read_data reflects read_addr and current register state in the same cycle.
REQ-013 ADR registers read {20'b0, 12-bit data}; read-only; written by hardware only.
REQ-014 ADCS write: EN, TE, FR, IE take write_data directly; SC writing 1 starts a sequence when EN=1 and idle, writing 0 has no effect; IF is write-1-to-clear.
REQ-015 States: IDLE, ISSUE, WAIT. IDLE->ISSUE on start (SC set by write, or trigger edge) with EN=1 and nonzero ADMSK.
REQ-016 ISSUE: ADC_C_Valid=1 with channel of lowest remaining mask cell (ascending order); SOP=1 on first command, EOP=1 on last; advance only on Valid&Ready; next command presented the following cycle.
REQ-017 ADC_C_Valid asserts the cycle after the start write/trigger edge; mask is latched at sequence start.
REQ-018 After last handshake go to WAIT until responses for all issued commands arrive (outstanding counter).
REQ-019 On ADC_R_Valid store ADC_R_Data into the cell matching ADC_R_Channel, in any state; unknown channels dropped.
REQ-020 Sequence completion: IF set; if FR=1 restart immediately (ISSUE, SC stays 1); else SC cleared, go IDLE.
REQ-021 Start with ADMSK=0: IF set and SC cleared next cycle, no commands issued.
REQ-022 IF hardware set and software clear in the same cycle: set wins.
REQ-023 ADC_Interrupt = IF & IE.
REQ-024 Clearing FR while running: current sequence completes, then SC clears.
REQ-025 EN written 0: ADC_C_Valid low next cycle, SC cleared, state IDLE; late responses still stored.
REQ-026 ADC_Trigger: two-flop synchronizer, rising-edge detect; starts sequence (sets SC) only when EN=1, TE=1, idle; ignored when busy.

Reset
REQ-027 RESET asserted: all registers, ADR contents, mask, state, synchronizer cleared to 0 immediately; ADC_C_Valid, SOP, EOP, ADC_Interrupt 0; ADC_C_Channel 0; mid-sequence reset aborts with no completion flag.

Configuration
REQ-028 Macro ADC_EXT_TRIGGER_EN: defined -> TE bit and ADC_Trigger path present per REQ-026; undefined -> TE reads 0, writes ignored, ADC_Trigger unused, no synchronizer logic.

Verification
REQ-029 Write ADMSK=0x002, read ADMSK -> 0x002; write ADCS=0x17 -> next cycle C_Valid=1, channel 1, SOP=EOP=1; response ch1 data 0x5A5 -> ADR1=0x5A5, ADCS reads 0x35, ADC_Interrupt=1.
REQ-030 Write ADCS=0x35 -> ADCS reads 0x15, ADC_Interrupt=0.
REQ-031 ADMSK=0x00C, pulse ADC_Trigger (ADCS=0x15) -> commands ch2 (SOP=1,EOP=0), ch3 (SOP=0,EOP=1); after both responses IF=1; trigger with TE=0 -> no command.
REQ-032 ADMSK=0x030, ADCS=0x0B -> repeating ch4,ch5 sequences, IF set each pass; write ADCS=0x03 -> current pass finishes, ADCS reads 0x21 (SC cleared, IF set).
REQ-033 ADMSK=0x100, ADCS=0x17 -> command channel 17; response 0x7FF ch17 -> ADRT=0x7FF.
REQ-034 Hold ADC_C_Ready=0 mid-sequence, write ADCS=0 -> C_Valid=0 next cycle, ADCS reads 0; assert RESET mid-sequence -> all outputs 0 at once.

Source files
------------

// File: rtl/adc_max10_core.sv
// ---------------------------------------------------------------------------
// adc_max10_core
//
// Register-mapped sequencer for the MAX10 modular ADC IP. Software selects a
// set of conversion cells in ADMSK. A start (SC write or external trigger)
// latches the mask and issues one Avalon-ST command per selected cell, in
// ascending cell order. It then waits until a response has arrived for every
// command it issued. Each response is stored in the result register of the
// cell that owns the response channel.
//
// Register map (word addresses):
//   0  ADCS   {IF[5], IE[4], FR[3], TE[2], SC[1], EN[0]}
//   1  ADMSK  cell mask, bits 8:0 (cells 0..7 -> channels 0..7, cell 8 -> 17)
//   2..9      ADR0..ADR7 results, {20'b0, data[11:0]}, read-only
//   10        ADRT temperature-sensor result (cell 8), read-only
//   others    read 0, writes ignored
//
// Ports:
//   CLK, RESET             clock, asynchronous active-high reset
//   read_addr/read_data    combinational register read port
//   write_addr/write_data/write_enable   register write port
//   ADC_C_*                Avalon-ST command source to the ADC IP
//   ADC_R_*                Avalon-ST response sink from the ADC IP
//   ADC_Trigger            asynchronous external start input
//   ADC_Interrupt          IF & IE
//
// Build option: define ADC_EXT_TRIGGER_EN to include the TE bit and the
// ADC_Trigger synchronizer. When it is undefined, TE reads 0 and ADC_Trigger
// is ignored.
// ---------------------------------------------------------------------------
module adc_max10_core #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [31:0]           read_data,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [31:0]           write_data,
    input  logic                  write_enable,
    output logic                  ADC_C_Valid,
    output logic                  ADC_C_SOP,
    output logic                  ADC_C_EOP,
    output logic [4:0]            ADC_C_Channel,
    input  logic                  ADC_C_Ready,
    input  logic                  ADC_R_Valid,
    input  logic                  ADC_R_SOP,
    input  logic                  ADC_R_EOP,
    input  logic [4:0]            ADC_R_Channel,
    input  logic [11:0]           ADC_R_Data,
    input  logic                  ADC_Trigger,
    output logic                  ADC_Interrupt
);

    localparam int         NUM_CELLS    = 9;
    localparam int         TEMP_CELL    = 8;
    localparam logic [4:0] TEMP_CHANNEL = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic                 en_reg, fr_reg, ie_reg;
    logic                 sc_reg, sc_next;
    logic                 if_reg, if_next, if_set;
    logic                 te_bit;
    logic [8:0]           admsk_reg;
    logic [8:0]           seq_mask_reg, seq_mask_next;
    logic                 first_reg, first_next;
    logic [4:0]           outstanding_reg, outstanding_next, outstanding_calc;
    logic [11:0]          adr_reg [NUM_CELLS];
    logic [NUM_CELLS-1:0] cell_hit;

    logic [31:0]          wr_idx, rd_idx;
    logic                 adcs_we, admsk_we;
    logic                 sw_start, trig_start, start_req, abort_req;
    logic                 handshake, resp_dec, fr_new;
    logic [8:0]           low_onehot, seq_mask_after;
    logic [4:0]           cmd_chan;

    assign wr_idx   = 32'(write_addr);
    assign rd_idx   = 32'(read_addr);
    assign adcs_we  = write_enable && (wr_idx == 32'd0);
    assign admsk_we = write_enable && (wr_idx == 32'd1);

    // A software start uses the EN value being written, so a single write of
    // EN|SC from the disabled state starts a sequence.
    assign sw_start  = adcs_we && write_data[0] && write_data[1] && (state_reg == ST_IDLE);
    assign abort_req = adcs_we && !write_data[0];
    assign start_req = sw_start || trig_start;
    assign fr_new    = adcs_we ? write_data[3] : fr_reg;

    // ------------------------------------------------------------------
    // External trigger path
    // ------------------------------------------------------------------
`ifdef ADC_EXT_TRIGGER_EN
    logic te_reg;
    logic trig_meta_reg, trig_sync_reg, trig_prev_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            te_reg        <= 1'b0;
            trig_meta_reg <= 1'b0;
            trig_sync_reg <= 1'b0;
            trig_prev_reg <= 1'b0;
        end else begin
            if (adcs_we) begin
                te_reg <= write_data[2];
            end
            trig_meta_reg <= ADC_Trigger;
            trig_sync_reg <= trig_meta_reg;
            trig_prev_reg <= trig_sync_reg;
        end
    end

    assign te_bit     = te_reg;
    assign trig_start = trig_sync_reg && !trig_prev_reg && en_reg && te_reg
                        && (state_reg == ST_IDLE);

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ADC_R_SOP, ADC_R_EOP, write_data[31:9]};
`else
    assign te_bit     = 1'b0;
    assign trig_start = 1'b0;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ADC_R_SOP, ADC_R_EOP, write_data[31:9],
                             write_data[2], ADC_Trigger};
`endif

    // ------------------------------------------------------------------
    // Command generation: the lowest remaining mask bit is the next cell.
    // ------------------------------------------------------------------
    assign low_onehot     = seq_mask_reg & (~seq_mask_reg + 9'd1);
    assign seq_mask_after = seq_mask_reg & ~low_onehot;

    always_comb begin
        cmd_chan = 5'd0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (low_onehot[i]) begin
                cmd_chan = (i == TEMP_CELL) ? TEMP_CHANNEL : 5'(i);
            end
        end
    end

    assign ADC_C_Valid   = (state_reg == ST_ISSUE);
    assign ADC_C_SOP     = ADC_C_Valid && first_reg;
    assign ADC_C_EOP     = ADC_C_Valid && (seq_mask_after == 9'd0);
    assign ADC_C_Channel = ADC_C_Valid ? cmd_chan : 5'd0;
    assign ADC_Interrupt = if_reg && ie_reg;

    // Outstanding count: +1 per accepted command, -1 per response. Responses
    // arriving with nothing outstanding (e.g. after an abort) do not count.
    assign handshake        = ADC_C_Valid && ADC_C_Ready;
    assign resp_dec         = ADC_R_Valid && (outstanding_reg != 5'd0);
    assign outstanding_calc = outstanding_reg + {4'd0, handshake} - {4'd0, resp_dec};

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg       <= ST_IDLE;
            seq_mask_reg    <= 9'd0;
            first_reg       <= 1'b0;
            outstanding_reg <= 5'd0;
            sc_reg          <= 1'b0;
            if_reg          <= 1'b0;
        end else begin
            state_reg       <= state_next;
            seq_mask_reg    <= seq_mask_next;
            first_reg       <= first_next;
            outstanding_reg <= outstanding_next;
            sc_reg          <= sc_next;
            if_reg          <= if_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        seq_mask_next    = seq_mask_reg;
        first_next       = first_reg;
        outstanding_next = outstanding_calc;
        sc_next          = sc_reg;
        if_set           = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start_req) begin
                    if (admsk_reg == 9'd0) begin
                        // Empty mask: complete at once without issuing.
                        if_set  = 1'b1;
                        sc_next = 1'b0;
                    end else begin
                        state_next    = ST_ISSUE;
                        seq_mask_next = admsk_reg;
                        first_next    = 1'b1;
                        sc_next       = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (handshake) begin
                    seq_mask_next = seq_mask_after;
                    first_next    = 1'b0;
                    if (seq_mask_after == 9'd0) begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Complete on the same edge the final response is taken.
                if (outstanding_calc == 5'd0) begin
                    if_set = 1'b1;
                    if (fr_new && (admsk_reg != 9'd0)) begin
                        state_next    = ST_ISSUE;
                        seq_mask_next = admsk_reg;
                        first_next    = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                        sc_next    = 1'b0;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Disabling the block abandons the sequence; results still land.
        if (abort_req) begin
            state_next       = ST_IDLE;
            seq_mask_next    = 9'd0;
            first_next       = 1'b0;
            outstanding_next = 5'd0;
            sc_next          = 1'b0;
        end
    end

    // Hardware set takes priority over a write-1-to-clear in the same cycle.
    assign if_next = if_set || (if_reg && !(adcs_we && write_data[5]));

    // ------------------------------------------------------------------
    // Software-owned control bits
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            en_reg    <= 1'b0;
            fr_reg    <= 1'b0;
            ie_reg    <= 1'b0;
            admsk_reg <= 9'd0;
        end else begin
            if (adcs_we) begin
                en_reg <= write_data[0];
                fr_reg <= write_data[3];
                ie_reg <= write_data[4];
            end
            if (admsk_we) begin
                admsk_reg <= write_data[8:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Result storage: each cell captures responses tagged with its channel.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
            localparam logic [4:0] CELL_CHANNEL = (gi == TEMP_CELL) ? TEMP_CHANNEL : 5'(gi);
            assign cell_hit[gi] = ADC_R_Valid && (ADC_R_Channel == CELL_CHANNEL);
        end
    endgenerate

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                adr_reg[i] <= 12'd0;
            end
        end else begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                if (cell_hit[i]) begin
                    adr_reg[i] <= ADC_R_Data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Combinational read mux
    // ------------------------------------------------------------------
    always_comb begin
        read_data = 32'd0;
        if (rd_idx == 32'd0) begin
            read_data = {26'd0, if_reg, ie_reg, fr_reg, te_bit, sc_reg, en_reg};
        end else if (rd_idx == 32'd1) begin
            read_data = {23'd0, admsk_reg};
        end else begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                if (rd_idx == 32'(i + 2)) begin
                    read_data = {20'd0, adr_reg[i]};
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_max10_core.sv
// ---------------------------------------------------------------------------
// tb_adc_max10_core
//
// Directed testbench for adc_max10_core. Inputs are driven 1 time unit after
// the rising edge, and outputs are sampled at that point. Each task covers
// one feature and checks its own results inline. Trigger behaviour depends
// on whether ADC_EXT_TRIGGER_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_max10_core;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  read_addr;
    logic [31:0] read_data;
    logic [3:0]  write_addr;
    logic [31:0] write_data;
    logic        write_enable;
    logic        ADC_C_Valid, ADC_C_SOP, ADC_C_EOP;
    logic [4:0]  ADC_C_Channel;
    logic        ADC_C_Ready;
    logic        ADC_R_Valid, ADC_R_SOP, ADC_R_EOP;
    logic [4:0]  ADC_R_Channel;
    logic [11:0] ADC_R_Data;
    logic        ADC_Trigger;
    logic        ADC_Interrupt;

    int checks = 0;
    int errors = 0;

`ifdef ADC_EXT_TRIGGER_EN
    localparam logic [31:0] TE_MASK = 32'h4;
`else
    localparam logic [31:0] TE_MASK = 32'h0;
`endif

    // {Valid, SOP, EOP, Channel} for compact command checks
    logic [7:0] cmd_obs;
    assign cmd_obs = {ADC_C_Valid, ADC_C_SOP, ADC_C_EOP, ADC_C_Channel};

    adc_max10_core #(.ADDR_WIDTH(4)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .read_addr     (read_addr),
        .read_data     (read_data),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .ADC_C_Valid   (ADC_C_Valid),
        .ADC_C_SOP     (ADC_C_SOP),
        .ADC_C_EOP     (ADC_C_EOP),
        .ADC_C_Channel (ADC_C_Channel),
        .ADC_C_Ready   (ADC_C_Ready),
        .ADC_R_Valid   (ADC_R_Valid),
        .ADC_R_SOP     (ADC_R_SOP),
        .ADC_R_EOP     (ADC_R_EOP),
        .ADC_R_Channel (ADC_R_Channel),
        .ADC_R_Data    (ADC_R_Data),
        .ADC_Trigger   (ADC_Trigger),
        .ADC_Interrupt (ADC_Interrupt)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        write_addr   = addr;
        write_data   = data;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        $display("WRITE addr=%0d data=0x%08h", addr, data);
    endtask

    task automatic rd(input logic [3:0] addr, output logic [31:0] data);
        read_addr = addr;
        #1;
        data = read_data;
        $display("READ  addr=%0d data=0x%08h", addr, data);
    endtask

    task automatic send_resp(input logic [4:0] ch, input logic [11:0] data);
        ADC_R_Valid   = 1'b1;
        ADC_R_SOP     = 1'b1;
        ADC_R_EOP     = 1'b1;
        ADC_R_Channel = ch;
        ADC_R_Data    = data;
        tick();
        ADC_R_Valid   = 1'b0;
        ADC_R_SOP     = 1'b0;
        ADC_R_EOP     = 1'b0;
        $display("RESP  ch=%0d data=0x%03h", ch, data);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        RESET = 1'b1;
        #12;
        if (cmd_obs !== 8'h00) begin $display("FAIL reset_cmd got %h exp 00", cmd_obs); errors++; end
        checks++;
        if (ADC_Interrupt !== 1'b0) begin $display("FAIL reset_irq got %b exp 0", ADC_Interrupt); errors++; end
        checks++;
        rd(4'd0, d);
        if (d !== 32'h0) begin $display("FAIL reset_adcs got %h exp 0", d); errors++; end
        checks++;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [31:0] d;
        wr(4'd1, 32'h002);
        rd(4'd1, d);
        if (d !== 32'h002) begin $display("FAIL admsk_rd got %h exp 002", d); errors++; end
        checks++;
        wr(4'd0, 32'h17);
        if (cmd_obs !== {1'b1, 1'b1, 1'b1, 5'd1}) begin $display("FAIL single_cmd got %h exp %h", cmd_obs, {1'b1, 1'b1, 1'b1, 5'd1}); errors++; end
        checks++;
        tick();
        if (ADC_C_Valid !== 1'b0) begin $display("FAIL single_valid_drop got %b exp 0", ADC_C_Valid); errors++; end
        checks++;
        send_resp(5'd1, 12'h5A5);
        rd(4'd3, d);
        if (d !== 32'h5A5) begin $display("FAIL adr1 got %h exp 5a5", d); errors++; end
        checks++;
        rd(4'd0, d);
        if (d !== (32'h31 | TE_MASK)) begin $display("FAIL single_adcs got %h exp %h", d, 32'h31 | TE_MASK); errors++; end
        checks++;
        if (ADC_Interrupt !== 1'b1) begin $display("FAIL single_irq got %b exp 1", ADC_Interrupt); errors++; end
        checks++;
    endtask

    task automatic test_clear_if();
        logic [31:0] d;
        wr(4'd0, 32'h35);
        rd(4'd0, d);
        if (d !== (32'h11 | TE_MASK)) begin $display("FAIL clear_adcs got %h exp %h", d, 32'h11 | TE_MASK); errors++; end
        checks++;
        if (ADC_Interrupt !== 1'b0) begin $display("FAIL clear_irq got %b exp 0", ADC_Interrupt); errors++; end
        checks++;
    endtask

    task automatic test_trigger();
        logic [31:0] d;
        int          seen;
        wr(4'd1, 32'h00C);
        wr(4'd0, 32'h15);
`ifdef ADC_EXT_TRIGGER_EN
        ADC_Trigger = 1'b1;
        for (int n = 0; n < 10 && !ADC_C_Valid; n++) tick();
        if (ADC_C_Valid !== 1'b1) begin $display("FAIL trig_timeout got %b exp 1", ADC_C_Valid); errors++; end
        checks++;
        ADC_Trigger = 1'b0;
        if (cmd_obs !== {1'b1, 1'b1, 1'b0, 5'd2}) begin $display("FAIL trig_cmd0 got %h exp %h", cmd_obs, {1'b1, 1'b1, 1'b0, 5'd2}); errors++; end
        checks++;
        tick();
        if (cmd_obs !== {1'b1, 1'b0, 1'b1, 5'd3}) begin $display("FAIL trig_cmd1 got %h exp %h", cmd_obs, {1'b1, 1'b0, 1'b1, 5'd3}); errors++; end
        checks++;
        tick();
        send_resp(5'd2, 12'h111);
        send_resp(5'd3, 12'h222);
        rd(4'd0, d);
        if (d !== 32'h35) begin $display("FAIL trig_adcs got %h exp 35", d); errors++; end
        checks++;
        rd(4'd4, d);
        if (d !== 32'h111) begin $display("FAIL adr2 got %h exp 111", d); errors++; end
        checks++;
        wr(4'd0, 32'h31);
`endif
        rd(4'd0, d);
        if (d !== 32'h11) begin $display("FAIL te_off_adcs got %h exp 11", d); errors++; end
        checks++;
        seen = 0;
        ADC_Trigger = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (ADC_C_Valid) seen++;
        end
        ADC_Trigger = 1'b0;
        if (seen !== 0) begin $display("FAIL trig_ignored got %0d cmds exp 0", seen); errors++; end
        checks++;
    endtask

    task automatic test_repeat();
        logic [31:0] d;
        wr(4'd1, 32'h030);
        wr(4'd0, 32'h0B);
        if (cmd_obs !== {1'b1, 1'b1, 1'b0, 5'd4}) begin $display("FAIL rep_cmd0 got %h exp %h", cmd_obs, {1'b1, 1'b1, 1'b0, 5'd4}); errors++; end
        checks++;
        tick();
        if (cmd_obs !== {1'b1, 1'b0, 1'b1, 5'd5}) begin $display("FAIL rep_cmd1 got %h exp %h", cmd_obs, {1'b1, 1'b0, 1'b1, 5'd5}); errors++; end
        checks++;
        tick();
        send_resp(5'd4, 12'h041);
        send_resp(5'd5, 12'h051);
        if (cmd_obs !== {1'b1, 1'b1, 1'b0, 5'd4}) begin $display("FAIL rep_restart got %h exp %h", cmd_obs, {1'b1, 1'b1, 1'b0, 5'd4}); errors++; end
        checks++;
        rd(4'd0, d);
        if (d !== 32'h2B) begin $display("FAIL rep_adcs_pass got %h exp 2b", d); errors++; end
        checks++;
        wr(4'd0, 32'h03);
        if (cmd_obs !== {1'b1, 1'b0, 1'b1, 5'd5}) begin $display("FAIL rep_last_cmd got %h exp %h", cmd_obs, {1'b1, 1'b0, 1'b1, 5'd5}); errors++; end
        checks++;
        tick();
        send_resp(5'd4, 12'h444);
        send_resp(5'd5, 12'h555);
        rd(4'd0, d);
        if (d !== 32'h21) begin $display("FAIL rep_adcs_stop got %h exp 21", d); errors++; end
        checks++;
        if (ADC_C_Valid !== 1'b0) begin $display("FAIL rep_stopped got %b exp 0", ADC_C_Valid); errors++; end
        checks++;
        rd(4'd7, d);
        if (d !== 32'h555) begin $display("FAIL adr5 got %h exp 555", d); errors++; end
        checks++;
    endtask

    task automatic test_temp_sensor();
        logic [31:0] d;
        wr(4'd1, 32'h100);
        wr(4'd0, 32'h17);
        if (cmd_obs !== {1'b1, 1'b1, 1'b1, 5'd17}) begin $display("FAIL temp_cmd got %h exp %h", cmd_obs, {1'b1, 1'b1, 1'b1, 5'd17}); errors++; end
        checks++;
        tick();
        send_resp(5'd17, 12'h7FF);
        rd(4'd10, d);
        if (d !== 32'h7FF) begin $display("FAIL adrt got %h exp 7ff", d); errors++; end
        checks++;
        send_resp(5'd20, 12'hABC);
        rd(4'd2, d);
        if (d !== 32'h0) begin $display("FAIL unknown_ch_adr0 got %h exp 0", d); errors++; end
        checks++;
        rd(4'd11, d);
        if (d !== 32'h0) begin $display("FAIL unmapped_rd got %h exp 0", d); errors++; end
        checks++;
    endtask

    task automatic test_zero_mask();
        logic [31:0] d;
        wr(4'd0, 32'h20);
        wr(4'd1, 32'h000);
        wr(4'd0, 32'h03);
        rd(4'd0, d);
        if (d !== 32'h21) begin $display("FAIL zero_mask_adcs got %h exp 21", d); errors++; end
        checks++;
        if (ADC_C_Valid !== 1'b0) begin $display("FAIL zero_mask_valid got %b exp 0", ADC_C_Valid); errors++; end
        checks++;
    endtask

    task automatic test_disable();
        logic [31:0] d;
        wr(4'd1, 32'h003);
        ADC_C_Ready = 1'b0;
        wr(4'd0, 32'h23);
        tick();
        if (cmd_obs !== {1'b1, 1'b1, 1'b0, 5'd0}) begin $display("FAIL stall_cmd got %h exp %h", cmd_obs, {1'b1, 1'b1, 1'b0, 5'd0}); errors++; end
        checks++;
        wr(4'd0, 32'h00);
        if (ADC_C_Valid !== 1'b0) begin $display("FAIL disable_valid got %b exp 0", ADC_C_Valid); errors++; end
        checks++;
        rd(4'd0, d);
        if (d !== 32'h0) begin $display("FAIL disable_adcs got %h exp 0", d); errors++; end
        checks++;
        ADC_C_Ready = 1'b1;
        send_resp(5'd0, 12'h0AB);
        rd(4'd2, d);
        if (d !== 32'h0AB) begin $display("FAIL late_resp got %h exp 0ab", d); errors++; end
        checks++;
    endtask

    task automatic test_reset_mid_sequence();
        logic [31:0] d;
        wr(4'd1, 32'h000);
        wr(4'd0, 32'h13);
        wr(4'd1, 32'h006);
        ADC_C_Ready = 1'b0;
        wr(4'd0, 32'h13);
        if (cmd_obs !== {1'b1, 1'b1, 1'b0, 5'd1}) begin $display("FAIL pre_reset_cmd got %h exp %h", cmd_obs, {1'b1, 1'b1, 1'b0, 5'd1}); errors++; end
        checks++;
        if (ADC_Interrupt !== 1'b1) begin $display("FAIL pre_reset_irq got %b exp 1", ADC_Interrupt); errors++; end
        checks++;
        #2;
        RESET = 1'b1;
        #1;
        if (cmd_obs !== 8'h00) begin $display("FAIL mid_reset_cmd got %h exp 00", cmd_obs); errors++; end
        checks++;
        if (ADC_Interrupt !== 1'b0) begin $display("FAIL mid_reset_irq got %b exp 0", ADC_Interrupt); errors++; end
        checks++;
        rd(4'd1, d);
        if (d !== 32'h0) begin $display("FAIL mid_reset_admsk got %h exp 0", d); errors++; end
        checks++;
        rd(4'd3, d);
        if (d !== 32'h0) begin $display("FAIL mid_reset_adr1 got %h exp 0", d); errors++; end
        checks++;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        ADC_C_Ready = 1'b1;
        tick();
        rd(4'd0, d);
        if (d !== 32'h0) begin $display("FAIL post_reset_adcs got %h exp 0", d); errors++; end
        checks++;
    endtask

    initial begin
        RESET         = 1'b1;
        read_addr     = 4'd0;
        write_addr    = 4'd0;
        write_data    = 32'd0;
        write_enable  = 1'b0;
        ADC_C_Ready   = 1'b1;
        ADC_R_Valid   = 1'b0;
        ADC_R_SOP     = 1'b0;
        ADC_R_EOP     = 1'b0;
        ADC_R_Channel = 5'd0;
        ADC_R_Data    = 12'd0;
        ADC_Trigger   = 1'b0;

        test_reset();
        test_single();
        test_clear_if();
        test_trigger();
        test_repeat();
        test_temp_sensor();
        test_zero_mask();
        test_disable();
        test_reset_mid_sequence();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
